// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared state type and address-width helper for multiport_reg_file
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regfile_state_t;

    function automatic int reg_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - clear-sweep sequencer: walks idx 0..DEPTH-1 zeroing one entry per cycle
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = reg_aw(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    regfile_state_t r_state;
    regfile_state_t w_state_nxt;
    logic [AW-1:0]  r_idx;
    logic [AW-1:0]  w_idx_nxt;

    // Reset parks the sweep at idx 0; it only advances once reset drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            CLEAR: begin
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == AW'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy    = (r_state == CLEAR);
    assign clr_we  = (r_state == CLEAR);
    assign clr_idx = r_idx;

endmodule

// File: rtl/multiport_reg_file.sv
// rtl/multiport_reg_file.sv - 2-write / NREAD-read register file with soft clear sweep
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module multiport_reg_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = reg_aw(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear_req,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    input  logic [1:0]             wr_en,
    input  logic [2*AW-1:0]        wr_addr,
    input  logic [2*WIDTH-1:0]     wr_data,
    output logic                   busy
);

    logic             w_busy;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_idx;

    logic [WIDTH-1:0] r_mem     [DEPTH];
    logic [WIDTH-1:0] r_rd_data [NREAD];

    logic [AW-1:0]    w_wr_addr [2];
    logic [WIDTH-1:0] w_wr_data [2];
    logic             w_wr_act  [2];
    logic [AW-1:0]    w_rd_addr [NREAD];
    logic [WIDTH-1:0] w_rd_val  [NREAD];

    regfile_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (w_busy),
        .clr_we    (w_clr_we),
        .clr_idx   (w_clr_idx)
    );

    // A pending clear outranks any write landing in the same cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_wr_addr[p] = wr_addr[p*AW +: AW];
            w_wr_data[p] = wr_data[p*WIDTH +: WIDTH];
            w_wr_act[p]  = wr_en[p] && !w_busy && !clear_req && !reset
                           && !((ZERO_REG != 0) && (w_wr_addr[p] == '0));
        end
    end

    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            w_rd_addr[i] = rd_addr[i*AW +: AW];
            w_rd_val[i]  = r_mem[w_rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_act[1] && (w_wr_addr[1] == w_rd_addr[i])) begin
                w_rd_val[i] = w_wr_data[1];
            end else if (w_wr_act[0] && (w_wr_addr[0] == w_rd_addr[i])) begin
                w_rd_val[i] = w_wr_data[0];
            end
`endif
            if ((ZERO_REG != 0) && (w_rd_addr[i] == '0)) begin
                w_rd_val[i] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREAD; i++) begin
            if (reset || w_busy) begin
                r_rd_data[i] <= '0;
            end else begin
                r_rd_data[i] <= w_rd_val[i];
            end
        end
    end

    // No reset on the array so it can map to RAM; the sweep does the clearing.
    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= '0;
        end
        for (int p = 0; p < 2; p++) begin
            if (w_wr_act[p]) begin
                r_mem[w_wr_addr[p]] <= w_wr_data[p];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_data[i*WIDTH +: WIDTH] = w_busy ? '0 : r_rd_data[i];
        end
    end

    assign busy = w_busy;

endmodule

// File: tb/tb_multiport_reg_file.sv
// tb/tb_multiport_reg_file.sv - directed and randomized checks of multiport_reg_file against an array model
module tb_multiport_reg_file;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   clear_req;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [1:0]             wr_en;
    logic [2*AW-1:0]        wr_addr;
    logic [2*WIDTH-1:0]     wr_data;
    logic                   busy;

    multiport_reg_file #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NREAD    (NREAD),
        .ZERO_REG (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: plain array, a count of sweep cycles left, last read results.
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_sweep;
    logic [WIDTH-1:0] m_rd  [NREAD];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic set_wr(input logic [1:0] en, input int a0, input logic [31:0] d0,
                          input int a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {AW'(a1), AW'(a0)};
        wr_data = {d1, d0};
    endtask

    task automatic tick();
        logic [WIDTH-1:0] nrd [NREAD];
        logic [AW-1:0]    ra, wa0, wa1;
        wa0 = wr_addr[0 +: AW];
        wa1 = wr_addr[AW +: AW];
        for (int i = 0; i < NREAD; i++) nrd[i] = '0;
        if (reset) begin
            m_sweep = DEPTH;
            for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        end else if (m_sweep > 0) begin
            m_sweep--;
        end else begin
            for (int i = 0; i < NREAD; i++) begin
                ra = rd_addr[i*AW +: AW];
                nrd[i] = m_mem[ra];
`ifdef REGFILE_BYPASS_EN
                if (!clear_req) begin
                    if (wr_en[1] && wa1 == ra) nrd[i] = wr_data[WIDTH +: WIDTH];
                    else if (wr_en[0] && wa0 == ra) nrd[i] = wr_data[0 +: WIDTH];
                end
`endif
                if (ra == 0) nrd[i] = '0;
            end
            if (clear_req) begin
                m_sweep = DEPTH;
                for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
            end else begin
                if (wr_en[0] && wa0 != 0) m_mem[wa0] = wr_data[0 +: WIDTH];
                if (wr_en[1] && wa1 != 0) m_mem[wa1] = wr_data[WIDTH +: WIDTH];
            end
        end
        for (int i = 0; i < NREAD; i++) m_rd[i] = nrd[i];
        @(posedge clock);
        #1;
        chk("busy", 32'(busy), 32'(m_sweep > 0));
        for (int i = 0; i < NREAD; i++) begin
            chk($sformatf("rd_data[%0d]", i), rd_data[i*WIDTH +: WIDTH],
                (m_sweep > 0) ? 32'h0 : m_rd[i]);
        end
    endtask

    task automatic idle_inputs();
        reset     = 1'b0;
        clear_req = 1'b0;
        set_wr(2'b00, 0, 32'h0, 0, 32'h0);
    endtask

    int cnt;

    initial begin
        m_sweep = 0;
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        idle_inputs();
        set_rd(0, 0);

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        set_rd(1, 2);
        set_wr(2'b11, 1, 32'hCAFE_0001, 2, 32'hCAFE_0002);
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("reset_sweep_len", 32'(cnt), 32'd32);
        set_wr(2'b00, 0, 32'h0, 0, 32'h0);
        tick();
        chk("sweep_write_lost0", rd_data[0 +: WIDTH], 32'h0);
        chk("sweep_write_lost1", rd_data[WIDTH +: WIDTH], 32'h0);

        set_wr(2'b01, 5, 32'hDEAD_BEEF, 0, 32'h0);
        tick();
        set_wr(2'b00, 0, 32'h0, 0, 32'h0);
        set_rd(5, 0);
        tick();
        chk("basic_rw", rd_data[0 +: WIDTH], 32'hDEAD_BEEF);

        set_wr(2'b11, 7, 32'h11, 7, 32'h22);
        tick();
        set_wr(2'b00, 0, 32'h0, 0, 32'h0);
        set_rd(7, 7);
        tick();
        chk("collision", rd_data[0 +: WIDTH], 32'h22);

        set_wr(2'b01, 0, 32'h55, 0, 32'h0);
        tick();
        set_wr(2'b00, 0, 32'h0, 0, 32'h0);
        set_rd(0, 0);
        tick();
        chk("zero_reg_p0", rd_data[0 +: WIDTH], 32'h0);
        chk("zero_reg_p1", rd_data[WIDTH +: WIDTH], 32'h0);

        set_wr(2'b01, 3, 32'h1234, 0, 32'h0);
        tick();
        set_wr(2'b01, 3, 32'hA5A5, 0, 32'h0);
        set_rd(0, 3);
        tick();
`ifdef REGFILE_BYPASS_EN
        chk("bypass", rd_data[WIDTH +: WIDTH], 32'hA5A5);
`else
        chk("bypass", rd_data[WIDTH +: WIDTH], 32'h1234);
`endif
        set_wr(2'b00, 0, 32'h0, 0, 32'h0);
        tick();
        chk("bypass_after", rd_data[WIDTH +: WIDTH], 32'hA5A5);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 11;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("clear_ignored_len", 32'(cnt), 32'd32);
        tick();
        chk("clear_zeroed", rd_data[WIDTH +: WIDTH], 32'h0);

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("reset_mid_sweep_len", 32'(cnt), 32'd32);

        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 149) == 0);
            clear_req = ($urandom_range(0, 59) == 0);
            set_rd($urandom_range(0, 7), $urandom_range(0, 7));
            set_wr(2'($urandom), $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 7), $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
